// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the static board bottom-up, drops full rows, compacts the survivors
// downward and clears the vacated top rows. Optional scoring output under LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [0:ROWS*COLS-1] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [0:ROWS*COLS-1] board_out,
  output logic [4:0]           lines_cleared,
  output logic [ROWS-1:0]      full_rows
`ifdef LINE_CLEAR_SCORE_EN
  ,
  input  logic                 score_clr,
  output logic [15:0]          score
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t                 state;
  logic [0:ROWS*COLS-1]   src;
  logic [COLS-1:0]        work [ROWS];
  logic [4:0]             rd;
  logic signed [5:0]      wr;
  logic [4:0]             cnt;
  logic [ROWS-1:0]        mask;
  logic [COLS-1:0]        cur_row;

  assign cur_row = src[rd*COLS +: COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      board_out     <= '0;
      lines_cleared <= '0;
      full_rows     <= '0;
      src           <= '0;
      rd            <= '0;
      wr            <= '0;
      cnt           <= '0;
      mask          <= '0;
      for (int r = 0; r < ROWS; r++) work[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src   <= board_in;
            rd    <= 5'(ROWS - 1);
            wr    <= 6'(ROWS - 1);
            cnt   <= '0;
            mask  <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (&cur_row) begin
            mask[rd] <= 1'b1;
            cnt      <= cnt + 5'd1;
          end else begin
            work[wr[4:0]] <= cur_row;
            wr            <= wr - 6'sd1;
          end
          if (rd == 5'd0) state <= FILL;
          else            rd    <= rd - 5'd1;
        end
        FILL: begin
          // A negative wr means no row was full, so nothing above the survivors needs clearing.
          for (int r = 0; r < ROWS; r++) begin
            if (!wr[5] && 6'(r) <= wr) begin
              work[r]                    <= '0;
              board_out[r*COLS +: COLS]  <= '0;
            end else begin
              board_out[r*COLS +: COLS]  <= work[r];
            end
          end
          lines_cleared <= cnt;
          full_rows     <= mask;
          done          <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  function automatic logic [3:0] score_step(input logic [4:0] n);
    case (n)
      5'd0:    return 4'd0;
      5'd1:    return 4'd1;
      5'd2:    return 4'd3;
      5'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // lines_cleared is already valid while DONE is held, so the add lands at the end of that cycle.
  always_ff @(posedge clk) begin
    if (rst)
      score <= '0;
    else if (state == DONE)
      score <= sat_add(score_clr ? 16'd0 : score, score_step(lines_cleared));
    else if (score_clr)
      score <= '0;
  end
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: directed and random boards checked against a row-list
// reference model, including done latency, ignored starts and reset abort.
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [0:N-1]   board_in;
  logic           busy;
  logic           done;
  logic [0:N-1]   board_out;
  logic [4:0]     lines_cleared;
  logic [ROWS-1:0] full_rows;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out),
    .lines_cleared(lines_cleared), .full_rows(full_rows)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:N-1]    b;
    logic [4:0]      n;
    logic [ROWS-1:0] m;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: keep the non-full rows in bottom-up order and stack them from the floor.
  function automatic exp_t model(input logic [0:N-1] b);
    exp_t            e;
    logic [COLS-1:0] surv[$];
    logic [COLS-1:0] row;
    e.b = '0;
    e.n = '0;
    e.m = '0;
    e.cyc = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[r*COLS +: COLS];
      if (row == {COLS{1'b1}}) begin
        e.m[r] = 1'b1;
        e.n    = e.n + 5'd1;
      end else begin
        surv.push_back(row);
      end
    end
    for (int i = 0; i < surv.size(); i++) e.b[(ROWS-1-i)*COLS +: COLS] = surv[i];
    return e;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("board_out", N'(board_out), N'(e.b));
        check("lines_cleared", N'(lines_cleared), N'(e.n));
        check("full_rows", N'(full_rows), N'(e.m));
        check("done_cycle", N'(cyc), N'(e.cyc));
        check("busy_in_done", N'(busy), N'(1'b1));
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60 && busy; i++) @(negedge clk);
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=1 required=0");
    end
  endtask

  task automatic issue(input logic [0:N-1] b, input bit spam);
    exp_t e;
    int   k;
    int   i;
    wait_idle();
    @(negedge clk);
    start    = 1'b1;
    board_in = b;
    @(posedge clk);
    #1;
    k     = cyc;
    e     = model(b);
    e.cyc = k + ROWS + 1;
    sb.push_back(e);
    board_in = ~b;
    if (!spam) start = 1'b0;
    @(negedge clk);
    check("busy_after_start", N'(busy), N'(1'b1));
    if (spam) begin
      for (i = 0; i < 40 && !done; i++) @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending required=none");
      sb.delete();
    end
  endtask

  function automatic logic [0:N-1] rand_board(input int full_odds);
    logic [0:N-1]    b;
    logic [COLS-1:0] row;
    for (int r = 0; r < ROWS; r++) begin
      if (full_odds > 0 && $urandom_range(full_odds - 1) == 0) begin
        row = '1;
      end else begin
        row = COLS'($urandom);
        if (row == {COLS{1'b1}}) row[0] = 1'b0;
      end
      b[r*COLS +: COLS] = row;
    end
    return b;
  endfunction

  logic [0:N-1] b;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", N'(busy), N'(1'b0));
    check("rst_done", N'(done), N'(1'b0));
    check("rst_board_out", N'(board_out), N'(0));
    check("rst_lines", N'(lines_cleared), N'(0));
    check("rst_full_rows", N'(full_rows), N'(0));
    rst = 1'b0;

    // Single full bottom row with a lone bit above it.
    b = '0;
    b[19*COLS +: COLS] = 10'b1111111111;
    b[18*COLS +: COLS] = 10'b0000000001;
    issue(b, 1'b0);
    drain();

    // Reset in the middle of a scan: no done, outputs back to zero.
    issue(rand_board(3), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", N'(busy), N'(1'b0));
    check("abort_board_out", N'(board_out), N'(0));
    check("abort_lines", N'(lines_cleared), N'(0));
    check("abort_full_rows", N'(full_rows), N'(0));
    sb.delete();
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Non-contiguous full rows.
    b = '0;
    b[19*COLS +: COLS] = 10'b1111111111;
    b[18*COLS +: COLS] = 10'b1010101010;
    b[17*COLS +: COLS] = 10'b1111111111;
    b[16*COLS +: COLS] = 10'b0100000000;
    issue(b, 1'b0);
    drain();

    // No full rows: output equals input.
    issue(rand_board(0), 1'b0);
    drain();

    // All rows full while start is held high through the run.
    b = '1;
    issue(b, 1'b1);
    drain();
    repeat (30) @(negedge clk);

    // Back-to-back random boards.
    for (int t = 0; t < 10; t++) begin
      issue(rand_board(1 + t % 4), 1'b0);
      drain();
    end

    // Empty board.
    issue('0, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
